// File: rtl/xalu.sv
// ============================================================================
// xalu : multi-cycle MULT/DIV/MADD unit owning the HI/LO register pair.
// Optional multiply-accumulate ops (7-10) are enabled by macro XALU_MADD_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module xalu (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef XALU_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

   localparam logic [3:0] C_MUL_CYCLES = 4'd5;
   localparam logic [3:0] C_DIV_CYCLES = 4'd10;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [3:0]  r_cnt,   w_cnt_nxt;
   logic [3:0]  r_op,    w_op_nxt;
   logic [31:0] r_a,     w_a_nxt;
   logic [31:0] r_b,     w_b_nxt;
   logic [31:0] r_hi,    w_hi_nxt;
   logic [31:0] r_lo,    w_lo_nxt;

   // Issue decode on the live op input
   logic w_issue_mul;
   logic w_issue_div;

   always_comb begin
      w_issue_mul = 1'b0;
      w_issue_div = 1'b0;
      case (op)
         OP_MULT, OP_MULTU: w_issue_mul = 1'b1;
`ifdef XALU_MADD_EN
         OP_MADD, OP_MADDU,
         OP_MSUB, OP_MSUBU: w_issue_mul = 1'b1;
`endif
         OP_DIV, OP_DIVU:   w_issue_div = 1'b1;
         default: ;
      endcase
   end

   // Signedness of the latched operation
   logic w_signed;

   always_comb begin
      w_signed = 1'b0;
      case (r_op)
         OP_MULT, OP_DIV: w_signed = 1'b1;
`ifdef XALU_MADD_EN
         OP_MADD, OP_MSUB: w_signed = 1'b1;
`endif
         default: ;
      endcase
   end

   // 64-bit product: sign-extending to 64 bits makes the low 64 bits of the
   // unsigned product equal the two's-complement signed product.
   logic [63:0] w_ma, w_mb, w_prod;

   assign w_ma   = {{32{w_signed & r_a[31]}}, r_a};
   assign w_mb   = {{32{w_signed & r_b[31]}}, r_b};
   assign w_prod = w_ma * w_mb;

   // Truncating division on magnitudes, then sign fix-up
   logic        w_neg_a, w_neg_b;
   logic [31:0] w_abs_a, w_abs_b, w_uquo, w_urem, w_quo, w_rem;
   logic        w_div_zero;

   assign w_neg_a    = w_signed & r_a[31];
   assign w_neg_b    = w_signed & r_b[31];
   assign w_abs_a    = w_neg_a ? (32'd0 - r_a) : r_a;
   assign w_abs_b    = w_neg_b ? (32'd0 - r_b) : r_b;
   assign w_div_zero = (r_b == 32'd0);
   assign w_uquo     = w_div_zero ? 32'd0 : (w_abs_a / w_abs_b);
   assign w_urem     = w_div_zero ? 32'd0 : (w_abs_a % w_abs_b);
   assign w_quo      = (w_neg_a ^ w_neg_b) ? (32'd0 - w_uquo) : w_uquo;
   assign w_rem      = w_neg_a ? (32'd0 - w_urem) : w_urem;

`ifdef XALU_MADD_EN
   // Accumulates onto HI/LO as they stand at the commit edge
   logic [63:0] w_acc;
   logic        w_is_sub;

   assign w_is_sub = (r_op == OP_MSUB) || (r_op == OP_MSUBU);
   assign w_acc    = w_is_sub ? ({r_hi, r_lo} - w_prod) : ({r_hi, r_lo} + w_prod);
`endif

   // Next-state and datapath update
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_op_nxt    = r_op;
      w_a_nxt     = r_a;
      w_b_nxt     = r_b;
      w_hi_nxt    = r_hi;
      w_lo_nxt    = r_lo;

      case (r_state)
         IDLE: begin
            if (start) begin
               if (w_issue_mul || w_issue_div) begin
                  w_state_nxt = RUN;
                  w_cnt_nxt   = w_issue_div ? C_DIV_CYCLES : C_MUL_CYCLES;
                  w_op_nxt    = op;
                  w_a_nxt     = A;
                  w_b_nxt     = B;
               end else if (op == OP_MTHI) begin
                  w_hi_nxt = A;
               end else if (op == OP_MTLO) begin
                  w_lo_nxt = A;
               end
            end
         end

         RUN: begin
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
               w_state_nxt = IDLE;
               case (r_op)
                  OP_MULT, OP_MULTU: begin
                     {w_hi_nxt, w_lo_nxt} = w_prod;
                  end
                  OP_DIV, OP_DIVU: begin
                     if (!w_div_zero) begin
                        w_hi_nxt = w_rem;
                        w_lo_nxt = w_quo;
                     end
                  end
`ifdef XALU_MADD_EN
                  OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                     {w_hi_nxt, w_lo_nxt} = w_acc;
                  end
`endif
                  default: ;
               endcase
            end
         end

         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
         r_op    <= 4'd0;
         r_a     <= 32'd0;
         r_b     <= 32'd0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_op    <= w_op_nxt;
         r_a     <= w_a_nxt;
         r_b     <= w_b_nxt;
         r_hi    <= w_hi_nxt;
         r_lo    <= w_lo_nxt;
      end
   end

   assign busy = (r_state == RUN);
   assign HI   = r_hi;
   assign LO   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_xalu.sv
// ============================================================================
// tb_xalu : directed self-checking bench for xalu (default or XALU_MADD_EN build).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_xalu;

   logic        clk;
   logic        reset;
   logic        start;
   logic [3:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   int n_vec = 0;
   int n_err = 0;

   xalu dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .HI    (HI),
      .LO    (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive a one-cycle start strobe; returns just after the issuing edge
   task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      A     = a;
      B     = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = 4'd0;
   endtask

   // Number of negedges with busy high before it falls, bounded
   task automatic busy_len(output int n);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!busy) break;
         n++;
      end
   endtask

   int len;

   initial begin
      reset = 1'b0;
      start = 1'b0;
      op    = 4'd0;
      A     = 32'd0;
      B     = 32'd0;
      repeat (2) @(negedge clk);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_hi", HI, 32'd0);
      chk("reset_lo", LO, 32'd0);
      reset = 1'b1;

      // MULT -2 * 3
      issue(4'd1, 32'hFFFF_FFFE, 32'd3);
      busy_len(len);
      chk("mult_len", len, 32'd5);
      chk("mult_hi", HI, 32'hFFFF_FFFF);
      chk("mult_lo", LO, 32'hFFFF_FFFA);

      // MULTU max * max
      issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      busy_len(len);
      chk("multu_len", len, 32'd5);
      chk("multu_hi", HI, 32'hFFFF_FFFE);
      chk("multu_lo", LO, 32'h0000_0001);

      // DIVU 100 / 7
      issue(4'd4, 32'd100, 32'd7);
      busy_len(len);
      chk("divu_len", len, 32'd10);
      chk("divu_lo", LO, 32'd14);
      chk("divu_hi", HI, 32'd2);

      // DIV -7 / 2
      issue(4'd3, 32'hFFFF_FFF9, 32'd2);
      busy_len(len);
      chk("div_len", len, 32'd10);
      chk("div_lo", LO, 32'hFFFF_FFFD);
      chk("div_hi", HI, 32'hFFFF_FFFF);

      // MTHI 5 then DIV by zero
      issue(4'd5, 32'd5, 32'd0);
      @(negedge clk);
      chk("mthi_busy", {31'd0, busy}, 32'd0);
      chk("mthi_hi", HI, 32'd5);
      chk("mthi_lo", LO, 32'hFFFF_FFFD);
      issue(4'd3, 32'd9, 32'd0);
      busy_len(len);
      chk("div0_len", len, 32'd10);
      chk("div0_hi", HI, 32'd5);
      chk("div0_lo", LO, 32'hFFFF_FFFD);

      // NOP and undefined op with start
      issue(4'd0, 32'h1234_5678, 32'd1);
      issue(4'd15, 32'h1234_5678, 32'd1);
      @(negedge clk);
      chk("nop_busy", {31'd0, busy}, 32'd0);
      chk("nop_hi", HI, 32'd5);
      chk("nop_lo", LO, 32'hFFFF_FFFD);

      // MTLO/MTHI then MADDU 1*1
      issue(4'd6, 32'hFFFF_FFFF, 32'd0);
      issue(4'd5, 32'd0, 32'd0);
      issue(4'd8, 32'd1, 32'd1);
      busy_len(len);
`ifdef XALU_MADD_EN
      chk("maddu_len", len, 32'd5);
      chk("maddu_hi", HI, 32'd1);
      chk("maddu_lo", LO, 32'd0);
      // MSUB: 0x1_00000000 - 6
      issue(4'd9, 32'd2, 32'd3);
      busy_len(len);
      chk("msub_len", len, 32'd5);
      chk("msub_hi", HI, 32'd0);
      chk("msub_lo", LO, 32'hFFFF_FFFA);
`else
      chk("maddu_off_len", len, 32'd0);
      chk("maddu_off_hi", HI, 32'd0);
      chk("maddu_off_lo", LO, 32'hFFFF_FFFF);
`endif

      // MULT 4*5 with a second MULT 7*7 attempted at cycle 2
      issue(4'd1, 32'd4, 32'd5);
      len = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         start = (i == 1);
         op    = (i == 1) ? 4'd1 : 4'd0;
         A     = 32'd7;
         B     = 32'd7;
         if (!busy) break;
         len++;
      end
      start = 1'b0;
      op    = 4'd0;
      chk("ignore_len", len, 32'd5);
      chk("ignore_hi", HI, 32'd0);
      chk("ignore_lo", LO, 32'd20);

      // MULTU aborted by reset at cycle 3
      issue(4'd2, 32'd3, 32'd4);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_hi", HI, 32'd0);
      chk("abort_lo", LO, 32'd0);
      #2;
      reset = 1'b1;
      repeat (12) @(negedge clk);
      chk("abort_late_busy", {31'd0, busy}, 32'd0);
      chk("abort_late_lo", LO, 32'd0);

      // First op after reset release
      issue(4'd2, 32'd3, 32'd4);
      busy_len(len);
      chk("post_len", len, 32'd5);
      chk("post_hi", HI, 32'd0);
      chk("post_lo", LO, 32'd12);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation bound expired");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
